reg_file_bypass: RTL and testbench

REG_FILE_BYPASS -- requirements
Module: reg_file_bypass

---
 rtl/cpu_pkg.sv | 12 +
 rtl/mux32_1.sv | 12 +
 rtl/reg_file_bypass.sv | 89 ++++++++
 tb/tb_reg_file_bypass.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for the integer register file.
package cpu_pkg;

    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 31;
    localparam int IDX_W    = 5;
    localparam int MUX_N    = 1 << IDX_W;

    typedef logic [IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/mux32_1.sv
// One-bit 32:1 selector used as the per-bit read column of the register file.
module mux32_1
    import cpu_pkg::*;
(
    input  logic [MUX_N-1:0] d,
    input  reg_idx_t         sel,
    output logic             y
);

    assign y = d[sel];

endmodule

// File: rtl/reg_file_bypass.sv
// Two-read/one-write register file with a hardwired zero register,
// same-cycle write-to-read bypass and a saturating write counter.
module reg_file_bypass
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS,
    parameter int ZERO_REG = cpu_pkg::ZERO_REG
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  reg_idx_t          wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  reg_idx_t          rd_addr_a,
    input  reg_idx_t          rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic [7:0]        wr_count
);

    logic [MUX_N-1:0]  wr_sel;
    logic              commit;
    logic [DATA_W-1:0] q_arr [MUX_N];
    logic [MUX_N-1:0]  col   [DATA_W];
    logic [DATA_W-1:0] mux_a;
    logic [DATA_W-1:0] mux_b;
    logic              byp_a;
    logic              byp_b;

    // One-hot write enable; the zero register and indices past NUM_REGS never fire.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        wr_sel = '0;
        if (wr_en)
            wr_sel[wr_addr] = 1'b1;
        for (int i = 0; i < MUX_N; i++)
            if (i == ZERO_REG || i >= NUM_REGS)
                wr_sel[i] = 1'b0;
    end

    assign commit = |wr_sel;

    for (genvar i = 0; i < MUX_N; i++) begin : g_reg
        if (i == ZERO_REG || i >= NUM_REGS) begin : g_zero
            assign q_arr[i] = '0;
        end else begin : g_store
            logic [DATA_W-1:0] q;
            // NOTE: storage is flops, not a RAM macro, so it can and must clear on reset;
            // sequential state is updated with non-blocking assignments only.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    q <= '0;
                else if (wr_sel[i])
                    q <= wr_data;
            end
            assign q_arr[i] = q;
        end
    end

    // Transpose storage into per-bit columns feeding the 32:1 selectors.
    always_comb begin
        for (int b = 0; b < DATA_W; b++) begin
            col[b] = '0;
            for (int i = 0; i < MUX_N; i++)
                col[b][i] = q_arr[i][b];
        end
    end

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        mux32_1 u_mux_a (.d(col[b]), .sel(rd_addr_a), .y(mux_a[b]));
        mux32_1 u_mux_b (.d(col[b]), .sel(rd_addr_b), .y(mux_b[b]));
    end

    // wr_sel already excludes the zero register, so it doubles as the bypass match.
    assign byp_a = wr_sel[rd_addr_a];
    assign byp_b = wr_sel[rd_addr_b];

    assign rd_data_a = !rst_n ? '0 : (byp_a ? wr_data : mux_a);
    assign rd_data_b = !rst_n ? '0 : (byp_b ? wr_data : mux_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_count <= '0;
        else if (commit && wr_count != 8'hFF)
            wr_count <= wr_count + 8'd1;
    end

endmodule

// File: tb/tb_reg_file_bypass.sv
// Directed self-checking bench for reg_file_bypass.
module tb_reg_file_bypass;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    reg_idx_t    wr_addr;
    logic [63:0] wr_data;
    reg_idx_t    rd_addr_a;
    reg_idx_t    rd_addr_b;
    logic [63:0] rd_data_a;
    logic [63:0] rd_data_b;
    logic [7:0]  wr_count;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] model [32];
    int          cnt_model;

    reg_file_bypass dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_count  (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic read_both(input string tag, input int idx, input logic [63:0] exp);
        rd_addr_a = reg_idx_t'(idx);
        rd_addr_b = reg_idx_t'(idx);
        #1;
        check($sformatf("%s_a[%0d]", tag, idx), rd_data_a, exp);
        check($sformatf("%s_b[%0d]", tag, idx), rd_data_b, exp);
    endtask

    task automatic write_reg(input int idx, input logic [63:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = reg_idx_t'(idx);
        wr_data = d;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 5'd4;
        wr_data   = 64'h5555;
        rd_addr_a = 5'd4;
        rd_addr_b = 5'd4;

        // Write presented during reset: no bypass, no storage.
        #2;
        check("rst_bypass_a", rd_data_a, 64'h0);
        check("rst_bypass_b", rd_data_b, 64'h0);
        repeat (2) @(posedge clk);
        #3;
        wr_en = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 32; i++)
            read_both("reset", i, 64'h0);
        check("reset_count", 64'(wr_count), 64'd0);

        write_reg(5, 64'h0000_0000_DEAD_BEEF);
        read_both("x5", 5, 64'h0000_0000_DEAD_BEEF);
        check("x5_count", 64'(wr_count), 64'd1);

        // Same-cycle bypass on both ports.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'h1234;
        rd_addr_a = 5'd7; rd_addr_b = 5'd7;
        #1;
        check("byp7_a", rd_data_a, 64'h1234);
        check("byp7_b", rd_data_b, 64'h1234);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        read_both("x7", 7, 64'h1234);
        check("x7_count", 64'(wr_count), 64'd2);

        // Bypass on A only; B reads stored X5.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 64'hCAFE;
        rd_addr_a = 5'd7; rd_addr_b = 5'd5;
        #1;
        check("byp_only_a", rd_data_a, 64'hCAFE);
        check("byp_only_b", rd_data_b, 64'h0000_0000_DEAD_BEEF);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        check("byp_only_count", 64'(wr_count), 64'd3);

        // Zero register: bypass disabled, write discarded.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
        rd_addr_a = 5'd31; rd_addr_b = 5'd31;
        #1;
        check("xzr_byp_a", rd_data_a, 64'h0);
        check("xzr_byp_b", rd_data_b, 64'h0);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        read_both("xzr", 31, 64'h0);
        check("xzr_count", 64'(wr_count), 64'd3);
        read_both("xzr_x5", 5, 64'h0000_0000_DEAD_BEEF);
        read_both("xzr_x7", 7, 64'hCAFE);
        read_both("xzr_x30", 30, 64'h0);

        // Asynchronous reset mid-cycle clears state at once.
        write_reg(3, 64'hAA);
        read_both("x3", 3, 64'hAA);
        #2;
        rst_n = 1'b0;
        #1;
        read_both("arst_x3", 3, 64'h0);
        read_both("arst_x5", 5, 64'h0);
        check("arst_count", 64'(wr_count), 64'd0);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h55;
        @(posedge clk);
        #1;
        read_both("rst_wr_x3", 3, 64'h0);
        // Release mid-cycle with a write pending: taken on the first edge.
        wr_addr = 5'd9; wr_data = 64'h99;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        read_both("first_wr_x3", 3, 64'h0);
        read_both("first_wr_x9", 9, 64'h99);
        check("first_wr_count", 64'(wr_count), 64'd1);

        // Saturation run with a reference model.
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        model[9]  = 64'h99;
        cnt_model = 1;
        for (int k = 0; k < 300; k++) begin
            int a;
            logic [63:0] d;
            a = 1 + (k % 30);
            d = 64'(k + 1) * 64'h9E37_79B9_7F4A_7C15;
            write_reg(a, d);
            model[a]  = d;
            cnt_model = (cnt_model < 255) ? cnt_model + 1 : 255;
            if (k == 252)
                check("sat_254", 64'(wr_count), 64'd254);
            if (k == 253)
                check("sat_255", 64'(wr_count), 64'd255);
        end
        check("sat_final", 64'(wr_count), 64'(cnt_model));
        for (int i = 0; i < 32; i++)
            read_both("final", i, model[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
